mul_issue_queue: RTL and testbench
==================================

MUL_ISSUE_QUEUE -- requirements
Module: mul_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, request FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter TIMEOUT, default 64, max cycles in RUN before abort (1..127).
REQ-003 SHALL have a single clock, mul_clk; reset is synchronous and active-low, named resetn.
REQ-004 SHALL provide these ports:
- mul_clk  in  1  clock, all state updates on rising edge
- resetn  in  1  synchronous active-low reset
- req_valid  in  1  request offered
- req_ready  out  1  FIFO can accept request
- req_signed  in  1  1 = signed multiply
- req_x  in  32  multiplicand
- req_y  in  32  multiplier
- mul_run  out  1  multiplier start/hold
- mul_signed  out  1  to multiplier
- mul_x  out  32  to multiplier
- mul_y  out  32  to multiplier
- mul_result  in  64  multiplier product
- mul_complete  in  1  product valid this cycle
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  64  product
- rsp_err  out  1  response is a timeout abort
- count  out  clog2(DEPTH)+1  FIFO occupancy

Function
REQ-005 SHALL accept a request when req_valid && req_ready; req_ready = (count < DEPTH), with no same-cycle bypass when full.
REQ-006 SHALL store {signed,x,y} in order; pointers wrap modulo DEPTH; push and pop in one cycle leave count unchanged.
REQ-007 SHALL drive mul_signed/mul_x/mul_y from the FIFO head at all times; the head is not popped until the operation ends, so operands are stable while mul_run=1.
REQ-008 SHALL implement FSM states IDLE and RUN.
REQ-009 IDLE->RUN when count>0 && (!rsp_valid || rsp_ready); mul_run is registered and is 1 exactly while in RUN.
REQ-010 RUN on mul_complete=1: capture mul_result into rsp_result, set rsp_valid=1, rsp_err=0, pop FIFO, go IDLE.
REQ-011 After each completion, mul_run SHALL be 0 for at least one cycle before the next op starts.
REQ-012 A 7-bit run counter SHALL clear on IDLE->RUN and increment each RUN cycle; if it reaches TIMEOUT without mul_complete: rsp_valid=1, rsp_err=1, rsp_result=0, pop, go IDLE.
REQ-013 mul_complete sampled in the same cycle the counter reaches TIMEOUT SHALL count as success (REQ-010 takes priority).
REQ-014 mul_complete while in IDLE SHALL be ignored.
REQ-015 rsp_valid SHALL clear on rsp_valid && rsp_ready unless a new capture occurs in the same cycle; while held, rsp_result and rsp_err stay stable.
REQ-016 Results SHALL leave in request order, one response per accepted request.
REQ-017 Product SHALL be forwarded unmodified; signedness is applied by the multiplier, 64-bit result (signed: sign-extended operands; unsigned: zero-extended).

Reset
REQ-018 While resetn=0 at a rising edge: FSM=IDLE, FIFO emptied (count=0), mul_run=0, rsp_valid=0, rsp_err=0, rsp_result=0, run counter=0.
REQ-019 Reset during RUN SHALL abandon the in-flight operation with no response; req_ready=1 from the first cycle after reset releases.
REQ-020 Operand outputs SHALL reflect the (empty) FIFO head storage and are don't-care while mul_run=0.

Verification
REQ-021 Unsigned: x=0xFFFFFFFF, y=0xFFFFFFFF, signed=0 -> rsp_result=0xFFFFFFFE00000001, rsp_err=0.
REQ-022 Signed: x=0x80000000, y=0x7FFFFFFF, then x=y=0xFFFFFFFF -> responses 0xC000000080000000 then 0x0000000000000001, in order, mul_run low >=1 cycle between them.
REQ-023 Backpressure: rsp_ready=0, push 5 requests with random mul_complete delay 0-3 cycles -> one response held stable, second op not started, count reaches 4, req_ready=0; release rsp_ready -> all 5 drain in order.
REQ-024 Timeout: mul_complete held 0 -> after 64 RUN cycles rsp_valid=1, rsp_err=1, rsp_result=0; next request then completes normally.
REQ-025 Reset mid-RUN with 3 queued -> next cycle mul_run=0, count=0, rsp_valid=0; no response for flushed requests.
REQ-026 Random soak (10k ops, random signed/x/y, random rsp_ready) -> every rsp_result equals 66-bit reference product [63:0].

Source files
------------

// File: rtl/mul_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module      : mul_issue_queue
//  Description : Request FIFO in front of an iterative multiplier. Each queued
//                {signed, x, y} request is issued from the FIFO head. The head
//                is popped when the multiplier reports completion, or when a
//                run-cycle watchdog expires. The product, or an error response
//                for a timeout, is held until the consumer accepts it.
//  Ports       : mul_clk / resetn          clock, synchronous active-low reset
//                req_valid/req_ready       request handshake
//                req_signed/req_x/req_y    request operands
//                mul_run                   multiplier start/hold (high in RUN)
//                mul_signed/mul_x/mul_y    operands from FIFO head
//                mul_result/mul_complete   product and its valid strobe
//                rsp_valid/rsp_ready       response handshake
//                rsp_result/rsp_err        product, timeout-abort flag
//                count                     FIFO occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_issue_queue #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                   mul_clk,
    input  logic                   resetn,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_signed,
    input  logic [31:0]            req_x,
    input  logic [31:0]            req_y,
    output logic                   mul_run,
    output logic                   mul_signed,
    output logic [31:0]            mul_x,
    output logic [31:0]            mul_y,
    input  logic [63:0]            mul_result,
    input  logic                   mul_complete,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [63:0]            rsp_result,
    output logic                   rsp_err,
    output logic [$clog2(DEPTH):0] count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_ent_w = 65;

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_run  = 1'b1;

    localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(DEPTH);
    // The counter value seen in the last permitted RUN cycle; the increment
    // out of this value is the one that "reaches" TIMEOUT.
    localparam logic [6:0]         c_to_last = 7'(TIMEOUT - 1);

    logic [c_ent_w-1:0] mem_q [DEPTH];
    logic [c_ent_w-1:0] mem_d [DEPTH];
    logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0] count_q,  count_d;
    logic [0:0]         state_q,  state_d;
    logic [6:0]         run_cnt_q, run_cnt_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q,   rsp_err_d;
    logic [63:0]        rsp_result_q, rsp_result_d;

    logic w_push;
    logic w_start;
    logic w_done_ok;
    logic w_done_to;
    logic w_pop;

    // No bypass: a full FIFO refuses even when a pop happens this cycle.
    assign req_ready = (count_q < c_depth);
    assign w_push    = req_valid && req_ready;

    // Start only when a response slot is free or being freed this cycle, so a
    // completion can never overwrite an unconsumed response.
    assign w_start   = (state_q == c_st_idle) && (count_q != '0) &&
                       (!rsp_valid_q || rsp_ready);

    // Completion wins over the watchdog in the same cycle.
    assign w_done_ok = (state_q == c_st_run) && mul_complete;
    assign w_done_to = (state_q == c_st_run) && !mul_complete &&
                       (run_cnt_q == c_to_last);
    assign w_pop     = w_done_ok || w_done_to;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            mem_d[wr_ptr_q] = {req_signed, req_x, req_y};
            wr_ptr_d        = wr_ptr_q + c_ptr_w'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_cnt_w'(1);
            2'b01:   count_d = count_q - c_cnt_w'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        run_cnt_d = run_cnt_q;
        case (state_q)
            c_st_idle: begin
                if (w_start) begin
                    state_d   = c_st_run;
                    run_cnt_d = 7'd0;
                end
            end
            c_st_run: begin
                if (w_pop) begin
                    state_d = c_st_idle;
                end else begin
                    run_cnt_d = run_cnt_q + 7'd1;
                end
            end
            default: state_d = c_st_idle;
        endcase
    end

    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_err_d    = rsp_err_q;
        rsp_result_d = rsp_result_q;
        if (w_done_ok) begin
            rsp_valid_d  = 1'b1;
            rsp_err_d    = 1'b0;
            rsp_result_d = mul_result;
        end else if (w_done_to) begin
            rsp_valid_d  = 1'b1;
            rsp_err_d    = 1'b1;
            rsp_result_d = 64'd0;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d  = 1'b0;
        end
    end

    // Entry storage carries no reset; the head is only meaningful in RUN.
    always_ff @(posedge mul_clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge mul_clk) begin
        if (!resetn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= c_st_idle;
            run_cnt_q    <= 7'd0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_result_q <= 64'd0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            run_cnt_q    <= run_cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_result_q <= rsp_result_d;
        end
    end

    assign mul_run    = (state_q == c_st_run);
    assign mul_signed = mem_q[rd_ptr_q][64];
    assign mul_x      = mem_q[rd_ptr_q][63:32];
    assign mul_y      = mem_q[rd_ptr_q][31:0];
    assign rsp_valid  = rsp_valid_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_result = rsp_result_q;
    assign count      = count_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_issue_queue
//  Description : Directed and randomised checks of mul_issue_queue against a
//                behavioural multiplier with programmable completion delay.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_issue_queue;

    logic        mul_clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic        req_signed;
    logic [31:0] req_x;
    logic [31:0] req_y;
    logic        mul_run;
    logic        mul_signed;
    logic [31:0] mul_x;
    logic [31:0] mul_y;
    logic [63:0] mul_result;
    logic        mul_complete;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_result;
    logic        rsp_err;
    logic [2:0]  count;

    always #5 mul_clk = ~mul_clk;

    mul_issue_queue #(.DEPTH(4), .TIMEOUT(64)) dut (
        .mul_clk      (mul_clk),
        .resetn       (resetn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_signed   (req_signed),
        .req_x        (req_x),
        .req_y        (req_y),
        .mul_run      (mul_run),
        .mul_signed   (mul_signed),
        .mul_x        (mul_x),
        .mul_y        (mul_y),
        .mul_result   (mul_result),
        .mul_complete (mul_complete),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_err      (rsp_err),
        .count        (count)
    );

    function automatic logic [63:0] ref_prod(input logic s, input logic [31:0] x,
                                             input logic [31:0] y);
        logic signed [65:0] a;
        logic signed [65:0] b;
        logic signed [65:0] p;
        a = s ? {{34{x[31]}}, x} : {34'd0, x};
        b = s ? {{34{y[31]}}, y} : {34'd0, y};
        p = a * b;
        return p[63:0];
    endfunction

    // Behavioural multiplier: completes mdl_delay cycles after RUN begins.
    int unsigned mdl_wait  = 0;
    int unsigned mdl_delay = 0;
    int unsigned mdl_lo    = 0;
    int unsigned mdl_hi    = 0;
    logic        mdl_en    = 1'b1;
    logic        mdl_force = 1'b0;

    always @(posedge mul_clk) begin
        if (!mul_run || mul_complete) begin
            mdl_wait  <= 0;
            mdl_delay <= $urandom_range(mdl_hi, mdl_lo);
        end else begin
            mdl_wait  <= mdl_wait + 1;
        end
    end
    assign mul_complete = mdl_force || (mdl_en && mul_run && (mdl_wait == mdl_delay));
    assign mul_result   = ref_prod(mul_signed, mul_x, mul_y);

    int          vectors    = 0;
    int          miscompares = 0;
    int          n_rsp      = 0;
    logic        acc        = 1'b0;
    logic        expect_to  = 1'b0;
    logic        hold_v     = 1'b0;
    logic [63:0] hold_r     = '0;
    logic        hold_e     = 1'b0;
    logic        prev_end   = 1'b0;
    logic        prev_run   = 1'b0;
    logic [63:0] prev_ops   = '0;
    logic [64:0] exp_q [$];
    logic [63:0] res_log [$];
    logic        err_log [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // One clock: monitor/score at the falling edge, return 1 unit after rise.
    task automatic cycle();
        logic [64:0] e;
        acc = 1'b0;
        @(negedge mul_clk);
        if (hold_v) begin
            chk("held_valid",  64'(rsp_valid), 64'd1);
            chk("held_result", rsp_result, hold_r);
            chk("held_err",    64'(rsp_err), 64'(hold_e));
        end
        if (prev_end) chk("run_gap", 64'(mul_run), 64'd0);
        if (prev_run && mul_run) chk("opnd_stable", {mul_x, mul_y}, prev_ops);
        if (req_valid && req_ready) begin
            acc = 1'b1;
            exp_q.push_back(expect_to ? {1'b1, 64'd0}
                                      : {1'b0, ref_prod(req_signed, req_x, req_y)});
        end
        if (rsp_valid && rsp_ready) begin
            n_rsp++;
            res_log.push_back(rsp_result);
            err_log.push_back(rsp_err);
            chk("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rsp_result", rsp_result, e[63:0]);
                chk("rsp_err", 64'(rsp_err), 64'(e[64]));
            end
        end
        hold_v   = rsp_valid && !rsp_ready;
        hold_r   = rsp_result;
        hold_e   = rsp_err;
        prev_end = mul_run && mul_complete;
        prev_run = mul_run;
        prev_ops = {mul_x, mul_y};
        @(posedge mul_clk);
        #1;
    endtask

    task automatic push(input logic s, input logic [31:0] x, input logic [31:0] y);
        int n;
        n = 0;
        req_signed = s;
        req_x      = x;
        req_y      = y;
        req_valid  = 1'b1;
        do begin
            cycle();
            n++;
        end while (!acc && n < 200);
        chk("push_accept", 64'(acc), 64'd1);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target, input int budget);
        int n;
        n = 0;
        while (n_rsp < target && n < budget) begin
            cycle();
            n++;
        end
        chk("rsp_count", 64'(n_rsp), 64'(target));
    endtask

    initial begin
        int base;
        int runs;
        int pushed;
        int c;

        resetn = 1'b0; req_valid = 1'b0; req_signed = 1'b0;
        req_x = '0; req_y = '0; rsp_ready = 1'b0;

        // Reset state
        cycle(); cycle();
        chk("rst_count",  64'(count), 64'd0);
        chk("rst_run",    64'(mul_run), 64'd0);
        chk("rst_valid",  64'(rsp_valid), 64'd0);
        chk("rst_err",    64'(rsp_err), 64'd0);
        chk("rst_result", rsp_result, 64'd0);
        resetn = 1'b1;
        cycle();
        chk("rst_ready", 64'(req_ready), 64'd1);

        // Unsigned all-ones
        rsp_ready = 1'b1;
        base = n_rsp;
        push(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_rsp(base + 1, 50);
        chk("unsigned_max", res_log[base], 64'hFFFF_FFFE_0000_0001);
        chk("unsigned_err", 64'(err_log[base]), 64'd0);

        // Signed pair, in order
        base = n_rsp;
        push(1'b1, 32'h8000_0000, 32'h7FFF_FFFF);
        push(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_rsp(base + 2, 50);
        chk("signed_min_max", res_log[base],     64'hC000_0000_8000_0000);
        chk("signed_m1_m1",   res_log[base + 1], 64'h0000_0000_0000_0001);

        // Backpressure: five requests with the consumer stalled
        mdl_lo = 0; mdl_hi = 3;
        rsp_ready = 1'b0;
        base = n_rsp;
        push(1'b0, 32'd3, 32'd5);
        push(1'b1, 32'hFFFF_FFFE, 32'd7);
        push(1'b0, 32'h0001_0000, 32'h0001_0000);
        push(1'b1, 32'hFFFF_FFFF, 32'h1234_5678);
        push(1'b0, 32'hFFFF_FFFF, 32'd2);
        repeat (8) cycle();
        chk("bp_count",  64'(count), 64'd4);
        chk("bp_ready",  64'(req_ready), 64'd0);
        chk("bp_valid",  64'(rsp_valid), 64'd1);
        chk("bp_no_run", 64'(mul_run), 64'd0);
        chk("bp_held",   rsp_result, 64'd15);
        rsp_ready = 1'b1;
        wait_rsp(base + 5, 200);
        chk("bp_r0", res_log[base],     64'h0000_0000_0000_000F);
        chk("bp_r1", res_log[base + 1], 64'hFFFF_FFFF_FFFF_FFF2);
        chk("bp_r2", res_log[base + 2], 64'h0000_0001_0000_0000);
        chk("bp_r3", res_log[base + 3], 64'hFFFF_FFFF_EDCB_A988);
        chk("bp_r4", res_log[base + 4], 64'h0000_0001_FFFF_FFFE);

        // Timeout: multiplier never completes
        mdl_en = 1'b0; expect_to = 1'b1;
        base = n_rsp;
        push(1'b0, 32'd1, 32'd2);
        expect_to = 1'b0;
        runs = 0;
        c = 0;
        while (n_rsp < base + 1 && c < 200) begin
            cycle();
            c++;
            if (mul_run) runs++;
        end
        chk("to_cycles", 64'(runs), 64'd64);
        chk("to_count",  64'(n_rsp), 64'(base + 1));
        chk("to_err",    64'(err_log[base]), 64'd1);
        chk("to_result", res_log[base], 64'd0);

        // Completion on the last permitted RUN cycle is a success
        mdl_en = 1'b1; mdl_lo = 63; mdl_hi = 63;
        base = n_rsp;
        push(1'b0, 32'd9, 32'd9);
        runs = 0;
        c = 0;
        while (n_rsp < base + 1 && c < 200) begin
            cycle();
            c++;
            if (mul_run) runs++;
        end
        chk("edge_cycles", 64'(runs), 64'd64);
        chk("edge_result", res_log[base], 64'd81);
        chk("edge_err",    64'(err_log[base]), 64'd0);

        // Normal operation after the timeout
        mdl_lo = 0; mdl_hi = 0;
        base = n_rsp;
        push(1'b0, 32'd6, 32'd7);
        wait_rsp(base + 1, 50);
        chk("post_to_result", res_log[base], 64'd42);

        // Completion strobe while idle is ignored
        base = n_rsp;
        mdl_force = 1'b1;
        cycle(); cycle();
        mdl_force = 1'b0;
        cycle();
        chk("idle_cmpl_valid", 64'(rsp_valid), 64'd0);
        chk("idle_cmpl_count", 64'(n_rsp), 64'(base));

        // Reset while running with three more queued
        mdl_en = 1'b0;
        push(1'b0, 32'd11, 32'd1);
        push(1'b0, 32'd12, 32'd1);
        push(1'b0, 32'd13, 32'd1);
        push(1'b0, 32'd14, 32'd1);
        chk("pre_rst_run",   64'(mul_run), 64'd1);
        chk("pre_rst_count", 64'(count), 64'd4);
        base = n_rsp;
        resetn = 1'b0;
        cycle();
        chk("mid_rst_run",    64'(mul_run), 64'd0);
        chk("mid_rst_count",  64'(count), 64'd0);
        chk("mid_rst_valid",  64'(rsp_valid), 64'd0);
        chk("mid_rst_result", rsp_result, 64'd0);
        resetn = 1'b1;
        exp_q.delete();
        hold_v = 1'b0; prev_end = 1'b0; prev_run = 1'b0;
        mdl_en = 1'b1;
        cycle();
        chk("post_rst_ready", 64'(req_ready), 64'd1);
        repeat (10) cycle();
        chk("flushed_no_rsp", 64'(n_rsp), 64'(base));

        // Random soak
        mdl_lo = 0; mdl_hi = 1;
        base = n_rsp;
        pushed = 0;
        req_signed = 1'($urandom_range(0, 1));
        req_x = $urandom; req_y = $urandom;
        req_valid = 1'b1;
        c = 0;
        while (n_rsp < base + 10000 && c < 60000) begin
            rsp_ready = ($urandom_range(0, 4) != 0);
            cycle();
            c++;
            if (acc) begin
                pushed++;
                req_signed = 1'($urandom_range(0, 1));
                req_x = $urandom; req_y = $urandom;
            end
            req_valid = (pushed < 10000);
        end
        req_valid = 1'b0;
        chk("soak_count", 64'(n_rsp), 64'(base + 10000));
        chk("soak_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
